// File: rtl/uart_rx_cmd_ctrl.sv
// Command-frame parser behind the UART receiver: SYNC, ADDR, DATA, CHK -> register write strobe.
// Optional transmit-ack handshake is built when UART_CMD_ACK_EN is defined.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 52080,
  parameter int         CNT_W       = 16
) (
  input  logic       clk,
  input  logic       Rst_rx,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [7:0] err_cnt,
`ifdef UART_CMD_ACK_EN
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
`endif
  output logic       busy
);

  // state  | meaning
  // S_IDLE | hunting for SYNC_BYTE, other bytes dropped
  // S_ADDR | next byte is the register address
  // S_DATA | next byte is the register data
  // S_CHK  | next byte must equal addr ^ data
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

  state_t           state, state_nxt;
  logic [7:0]       addr_q, data_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout, wr_go, err_go;

  // Expiry fires on the edge at which the count would reach TIMEOUT_CYC-1.
  assign timeout = (state != S_IDLE) && !rx_done && (cnt == CNT_W'(TIMEOUT_CYC - 2));
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    err_go    = 1'b0;
    case (state)
      S_IDLE: if (rx_done && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
      S_ADDR: begin
        if (rx_done)      state_nxt = S_DATA;
        else if (timeout) begin state_nxt = S_IDLE; err_go = 1'b1; end
      end
      S_DATA: begin
        if (rx_done)      state_nxt = S_CHK;
        else if (timeout) begin state_nxt = S_IDLE; err_go = 1'b1; end
      end
      S_CHK: begin
        if (rx_done) begin
          state_nxt = S_IDLE;
          if (rx_data == (addr_q ^ data_q)) wr_go = 1'b1;
          else                              err_go = 1'b1;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_go    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_rx) begin
    if (!Rst_rx) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_nxt;
      wr_en     <= wr_go;
      frame_err <= err_go;
      if (state == S_IDLE || rx_done) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if (state == S_ADDR && rx_done) addr_q <= rx_data;
      if (state == S_DATA && rx_done) data_q <= rx_data;
      if (wr_go) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      if (err_go && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  end

`ifdef UART_CMD_ACK_EN
  logic       ack_pend;
  logic [7:0] ack_code;

  // A fresh outcome always replaces whatever ack is still waiting.
  always_ff @(posedge clk or negedge Rst_rx) begin
    if (!Rst_rx) begin
      ack_pend <= 1'b0;
      ack_code <= 8'h00;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      if (wr_go || err_go) begin
        ack_pend <= 1'b1;
        ack_code <= wr_go ? 8'h06 : 8'h15;
      end else if (ack_pend && !tx_busy) begin
        ack_pend <= 1'b0;
        tx_start <= 1'b1;
        tx_data  <= ack_code;
      end
    end
  end
`endif

endmodule
